// File: rtl/serial_result_tx.sv
// Bit-serial result transmitter: a small FIFO of result words feeding a framed
// serial line (start, LSB-first data, even parity, stop), idle high.
module serial_result_tx #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  input  logic [WIDTH-1:0]                     in_data,
  output logic                                 in_ready,
  input  logic                                 tx_hold,
  output logic                                 tx_out,
  output logic                                 tx_active,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state, state_nxt;
  logic [BW-1:0]    baud_cnt, baud_nxt;
  logic [IW-1:0]    bit_idx, bit_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt, shreg_shift;
  logic             parity_q, parity_nxt;
  logic             tx_nxt, active_nxt;

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_nxt;
  logic [WIDTH-1:0] head;
  logic             push, pop, load, can_start, baud_done, bit_last;

  assign push        = in_valid && in_ready;
  assign head        = mem[rd_ptr];
  assign can_start   = (fifo_count != '0) && !tx_hold;
  assign baud_done   = (baud_cnt == BW'(CLKS_PER_BIT - 1));
  assign bit_last    = (bit_idx == IW'(WIDTH - 1));
  assign shreg_shift = shreg >> 1;
  assign count_nxt   = fifo_count + CW'(push) - CW'(pop);

  // Frame sequencer: next state and next line value
  always_comb begin
    state_nxt  = state;
    baud_nxt   = baud_cnt;
    bit_nxt    = bit_idx;
    shreg_nxt  = shreg;
    parity_nxt = parity_q;
    tx_nxt     = tx_out;
    active_nxt = tx_active;
    load       = 1'b0;
    pop        = 1'b0;

    case (state)
      S_IDLE: begin
        if (can_start) load = 1'b1;
      end
      S_START: begin
        if (baud_done) begin
          state_nxt = S_DATA;
          baud_nxt  = '0;
          bit_nxt   = '0;
          tx_nxt    = shreg[0];
        end else begin
          baud_nxt = baud_cnt + BW'(1);
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_nxt = '0;
          if (bit_last) begin
            state_nxt = S_PARITY;
            tx_nxt    = parity_q;
          end else begin
            bit_nxt   = bit_idx + IW'(1);
            shreg_nxt = shreg_shift;
            tx_nxt    = shreg_shift[0];
          end
        end else begin
          baud_nxt = baud_cnt + BW'(1);
        end
      end
      S_PARITY: begin
        if (baud_done) begin
          state_nxt = S_STOP;
          baud_nxt  = '0;
          tx_nxt    = 1'b1;
        end else begin
          baud_nxt = baud_cnt + BW'(1);
        end
      end
      S_STOP: begin
        if (baud_done) begin
          baud_nxt = '0;
          if (can_start) begin
            load = 1'b1;
          end else begin
            state_nxt  = S_IDLE;
            active_nxt = 1'b0;
          end
        end else begin
          baud_nxt = baud_cnt + BW'(1);
        end
      end
      default: begin
        state_nxt  = S_IDLE;
        tx_nxt     = 1'b1;
        active_nxt = 1'b0;
      end
    endcase

    // Pop the head word and drive its start bit from this edge
    if (load) begin
      pop        = 1'b1;
      state_nxt  = S_START;
      baud_nxt   = '0;
      bit_nxt    = '0;
      shreg_nxt  = head;
      parity_nxt = ^head;
      tx_nxt     = 1'b0;
      active_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      parity_q   <= 1'b0;
      tx_out     <= 1'b1;
      tx_active  <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      in_ready   <= 1'b1;
    end else begin
      state      <= state_nxt;
      baud_cnt   <= baud_nxt;
      bit_idx    <= bit_nxt;
      shreg      <= shreg_nxt;
      parity_q   <= parity_nxt;
      tx_out     <= tx_nxt;
      tx_active  <= active_nxt;
      fifo_count <= count_nxt;
      in_ready   <= (count_nxt != CW'(FIFO_DEPTH));
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset: occupancy and pointers define validity
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_serial_result_tx.sv
// Bench for serial_result_tx: two instances (1 and 4 clocks per bit) checked
// by a queue scoreboard and a per-cycle line monitor.
module tb_serial_result_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] in_valid, in_ready, tx_hold, tx_out, tx_active;
  logic [7:0] in_data [2];
  logic [2:0] fifo_count [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_result_tx #(.WIDTH(8), .FIFO_DEPTH(4), .CLKS_PER_BIT(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_data(in_data[0]),
    .in_ready(in_ready[0]), .tx_hold(tx_hold[0]), .tx_out(tx_out[0]),
    .tx_active(tx_active[0]), .fifo_count(fifo_count[0])
  );

  serial_result_tx #(.WIDTH(8), .FIFO_DEPTH(4), .CLKS_PER_BIT(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_data(in_data[1]),
    .in_ready(in_ready[1]), .tx_hold(tx_hold[1]), .tx_out(tx_out[1]),
    .tx_active(tx_active[1]), .fifo_count(fifo_count[1])
  );

  // Words accepted but not yet started on the line, per instance
  logic [7:0]  q0[$];
  logic [7:0]  q1[$];
  int          avail     [2] = '{0, 0};
  bit          hold_edge [2] = '{0, 0};
  bit          in_frame  [2] = '{0, 0};
  bit          line_free [2] = '{1, 1};
  int          pos       [2] = '{0, 0};
  logic [10:0] frame     [2];

  function automatic int qsize(input int g);
    return (g == 0) ? q0.size() : q1.size();
  endfunction

  function automatic void qpush(input int g, input logic [7:0] w);
    if (g == 0) q0.push_back(w); else q1.push_back(w);
  endfunction

  function automatic logic [7:0] qpop(input int g);
    if (qsize(g) == 0) return 8'h00;
    return (g == 0) ? q0.pop_front() : q1.pop_front();
  endfunction

  function automatic void qclear(input int g);
    if (g == 0) q0.delete(); else q1.delete();
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Capture side: record acceptances and what the sequencer saw at each edge
  initial forever begin
    @(posedge clk);
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        avail[g]     = 0;
        hold_edge[g] = 1'b0;
        qclear(g);
      end else begin
        avail[g]     = qsize(g);
        hold_edge[g] = tx_hold[g];
        if (in_valid[g] && in_ready[g]) qpush(g, in_data[g]);
      end
    end
  end

  // A frame must start at an edge exactly when the line is free, a word is
  // queued and the host is not holding; bits are then compared cycle by cycle.
  task automatic mon_step(input int g);
    int         cpb;
    bit         starting;
    logic [7:0] w;
    cpb = (g == 0) ? 1 : 4;
    if (rst) begin
      in_frame[g]  = 1'b0;
      line_free[g] = 1'b1;
      return;
    end
    starting = !in_frame[g] && (tx_out[g] === 1'b0);
    check($sformatf("start_rule%0d", g), 32'(starting),
          32'(line_free[g] && avail[g] > 0 && !hold_edge[g]));
    if (starting) begin
      w           = qpop(g);
      frame[g]    = {1'b1, ^w, w, 1'b0};
      in_frame[g] = 1'b1;
      pos[g]      = 0;
    end
    if (in_frame[g]) begin
      check($sformatf("line%0d_bit%0d", g, pos[g] / cpb), 32'(tx_out[g]),
            32'(frame[g][pos[g] / cpb]));
      check($sformatf("active%0d", g), 32'(tx_active[g]), 32'd1);
      pos[g]++;
      if (pos[g] == 11 * cpb) in_frame[g] = 1'b0;
    end else begin
      check($sformatf("idle_line%0d", g), 32'(tx_out[g]), 32'd1);
      check($sformatf("idle_active%0d", g), 32'(tx_active[g]), 32'd0);
    end
    line_free[g] = !in_frame[g];
    check($sformatf("fifo_count%0d", g), 32'(fifo_count[g]), 32'(qsize(g)));
    check($sformatf("in_ready%0d", g), 32'(in_ready[g]), 32'(qsize(g) != 4));
  endtask

  initial forever begin
    @(negedge clk);
    mon_step(0);
    mon_step(1);
  end

  task automatic wait_idle(input int g);
    int n;
    n = 0;
    while ((qsize(g) != 0 || in_frame[g] || tx_active[g] !== 1'b0) && n < 3000) begin
      tick();
      n++;
    end
    check($sformatf("drain%0d", g), 32'(n < 3000), 32'd1);
    tick();
  endtask

  task automatic push_one(input int g, input logic [7:0] w);
    in_valid[g] = 1'b1;
    in_data[g]  = w;
    tick();
    in_valid[g] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bp [6];
    logic       acc;
    int         k, e, acc_e5, n_act;

    rst        = 1'b1;
    in_valid   = '0;
    tx_hold    = '0;
    in_data[0] = '0;
    in_data[1] = '0;
    repeat (2) tick();
    rst = 1'b0;
    for (int g = 0; g < 2; g++) begin
      check("rst_tx_out", 32'(tx_out[g]), 32'd1);
      check("rst_active", 32'(tx_active[g]), 32'd0);
      check("rst_count", 32'(fifo_count[g]), 32'd0);
      check("rst_ready", 32'(in_ready[g]), 32'd1);
    end

    // Single word 0xA5: start bit from the edge after acceptance
    push_one(0, 8'hA5);
    check("a5_before_start", 32'(tx_out[0]), 32'd1);
    tick();
    check("a5_start_bit", 32'(tx_out[0]), 32'd0);
    check("a5_count_popped", 32'(fifo_count[0]), 32'd0);
    wait_idle(0);

    push_one(0, 8'h01);
    wait_idle(0);

    // Back-pressure: six words with in_valid held high
    for (int i = 0; i < 6; i++) bp[i] = 8'(8'h31 + 8'(i * 37));
    k = 0; e = 0; acc_e5 = -1;
    in_valid[0] = 1'b1;
    in_data[0]  = bp[0];
    while (k < 6 && e < 100) begin
      acc = in_ready[0];
      tick();
      if (acc) begin
        if (k == 5) acc_e5 = e;
        k++;
      end
      if (e == 4) begin
        check("bp_full_count", 32'(fifo_count[0]), 32'd4);
        check("bp_full_ready", 32'(in_ready[0]), 32'd0);
      end
      e++;
      if (k < 6) in_data[0] = bp[k];
    end
    in_valid[0] = 1'b0;
    check("bp_word5_edge", 32'(acc_e5), 32'd13);
    wait_idle(0);

    // Hold raised mid-frame: current frame completes, next word waits
    in_valid[0] = 1'b1;
    in_data[0]  = 8'hC3;
    tick();
    in_data[0]  = 8'h3C;
    tick();
    in_valid[0] = 1'b0;
    repeat (3) tick();
    tx_hold[0] = 1'b1;
    repeat (12) tick();
    check("hold_line_high", 32'(tx_out[0]), 32'd1);
    check("hold_count", 32'(fifo_count[0]), 32'd1);
    check("hold_inactive", 32'(tx_active[0]), 32'd0);
    tx_hold[0] = 1'b0;
    tick();
    check("hold_release_start", 32'(tx_out[0]), 32'd0);
    wait_idle(0);

    // Four clocks per bit: 44-cycle frame
    push_one(1, 8'h3C);
    n_act = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (tx_active[1] === 1'b1) n_act++;
    end
    check("cpb4_frame_len", 32'(n_act), 32'd44);
    wait_idle(1);

    // Reset during data bit 3 with words still queued
    in_valid[1] = 1'b1;
    in_data[1]  = 8'h11;
    tick();
    in_data[1]  = 8'h22;
    tick();
    in_data[1]  = 8'h33;
    tick();
    in_valid[1] = 1'b0;
    repeat (15) tick();
    check("pre_rst_active", 32'(tx_active[1]), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_tx_out", 32'(tx_out[1]), 32'd1);
    check("mid_rst_active", 32'(tx_active[1]), 32'd0);
    check("mid_rst_count", 32'(fifo_count[1]), 32'd0);
    check("mid_rst_ready", 32'(in_ready[1]), 32'd1);
    push_one(1, 8'h5A);
    wait_idle(1);

    // Random traffic with random throttling on both instances
    for (int c = 0; c < 3000; c++) begin
      for (int g = 0; g < 2; g++) begin
        in_valid[g] = ($urandom_range(0, 2) != 0);
        in_data[g]  = 8'($urandom);
        if ($urandom_range(0, 19) == 0) tx_hold[g] = ~tx_hold[g];
      end
      tick();
    end
    in_valid = '0;
    tx_hold  = '0;
    wait_idle(0);
    wait_idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
